timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the interval counter.
REQ-002 Parameter SIZE, default 10: width of the interval counter and of each requested length.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-005 req  input  NUM_REQ  per-requester level request; held high until done or abort.
REQ-006 req_len  input  NUM_REQ*SIZE  packed lengths; slice i = req_len[i*SIZE +: SIZE]; sampled only at grant.
REQ-007 grant  output  NUM_REQ  one-hot (or zero) ownership of the shared counter.
REQ-008 done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-009 busy  output  1  high while state is RUN or DONE.
REQ-010 count  output  SIZE  current interval count of the owner; 0 when not RUN.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN, DONE only; no other encodings reachable.
REQ-012 IDLE: if any req bit high, the block SHALL select a winner, latch its length, and enter RUN on the next edge; otherwise stay IDLE.
REQ-013 Arbitration SHALL be round-robin: search starts at index last+1, wraps modulo NUM_REQ, first high req wins; last is updated to winner on entry to RUN.
REQ-014 Latched length L_eff SHALL equal req_len slice of winner, except 0 SHALL be treated as 1.
REQ-015 RUN: grant[winner]=1, all other grant bits 0; count starts at 0 on first RUN cycle and increments by 1 each cycle.
REQ-016 RUN SHALL last exactly L_eff cycles: when count == L_eff-1 and req[winner] high, next state DONE.
REQ-017 DONE: grant=0, done[winner]=1 for exactly one cycle, count=0, then IDLE unconditionally.
REQ-018 Abort: if req[winner] low on any RUN cycle, next state SHALL be IDLE, grant=0, count=0, no done pulse; last still updated.
REQ-019 Abort and final count coinciding SHALL be treated as abort (no done).
REQ-020 Changes to req_len during RUN SHALL have no effect on the current interval.
REQ-021 Requests from non-owners during RUN/DONE SHALL be ignored until IDLE; minimum gap between grants is one IDLE cycle.
REQ-022 count arithmetic SHALL be SIZE bits; L_eff max 2^SIZE-1, so count never wraps.
REQ-023 grant and done SHALL never be high in the same cycle; at most one bit of each high.

Reset
REQ-024 On reset low: state IDLE, grant=0, done=0, busy=0, count=0, last=NUM_REQ-1 (index 0 has first priority).
REQ-025 Reset asserted mid-RUN or in DONE SHALL drop grant and done immediately with no completion pulse.
REQ-026 After reset release, first arbitration SHALL occur on the first rising edge with reset high.

Verification
REQ-027 Single request: req=0001, len0=3 -> grant=0001 for 3 cycles with count 0,1,2; done=0001 one cycle; busy high 4 cycles.
REQ-028 Round-robin: req=1111 held, all len=1 -> grant order 0001,0010,0100,1000,0001 with one DONE and one IDLE cycle between grants.
REQ-029 Zero length: req=0100, len2=0 -> grant 1 cycle, count=0, then done=0100.
REQ-030 Abort: req=0010, len1=5, drop req1 after 2 grant cycles -> grant falls next edge, done stays 0, next arbitration starts from index 2.
REQ-031 Reset mid-RUN: len0=10, assert reset at count=4 -> grant, count, busy go 0 immediately; after release req=1001 grants index 0 first.
REQ-032 Max length: SIZE=10, len=1023 -> count reaches 1023-1=1022, no wrap, done pulse follows.

Source files
------------

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that lends one shared interval counter to NUM_REQ requesters.
// The owner keeps the counter for its latched length, or until it drops its request.
module timer_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int SIZE    = 10
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*SIZE-1:0] req_len,
   output logic [NUM_REQ-1:0]      grant,
   output logic [NUM_REQ-1:0]      done,
   output logic                    busy,
   output logic [SIZE-1:0]         count
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] last;
   logic [IDX_W-1:0] owner;
   logic [SIZE-1:0]  len_eff;

   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] cand;
   logic             win_valid;
   logic [SIZE-1:0]  win_len;
   logic [SIZE-1:0]  len_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_len
      assign len_arr[i] = req_len[i*SIZE +: SIZE];
   end

   // Scan from the slot after the previous owner so every requester gets a turn.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
      win_valid = 1'b0;
      win_idx   = last;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last) + k) % NUM_REQ);
         if (!win_valid && req[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_len = len_arr[win_idx];

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         last    <= IDX_W'(NUM_REQ - 1);
         owner   <= '0;
         len_eff <= '0;
         grant   <= '0;
         done    <= '0;
         busy    <= 1'b0;
         count   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= '0;
               if (win_valid) begin
                  state   <= RUN;
                  owner   <= win_idx;
                  last    <= win_idx;
                  // A zero length still gives the winner one counting cycle.
                  len_eff <= (win_len == '0) ? SIZE'(1) : win_len;
                  grant   <= NUM_REQ'(1) << win_idx;
                  busy    <= 1'b1;
                  count   <= '0;
               end
            end
            RUN: begin
               // Abort takes priority over completion when both land on the same cycle.
               if (!req[owner]) begin
                  state <= IDLE;
                  grant <= '0;
                  busy  <= 1'b0;
                  count <= '0;
               end else if (count == len_eff - SIZE'(1)) begin
                  state <= DONE;
                  grant <= '0;
                  done  <= NUM_REQ'(1) << owner;
                  count <= '0;
               end else begin
                  count <= count + SIZE'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= '0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               done  <= '0;
               busy  <= 1'b0;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: hand-computed grant/done/count sequences
// for single, round-robin, zero-length, abort, reset and max-length cases.
module tb_timer_arbiter;

   localparam int NUM_REQ = 4;
   localparam int SIZE    = 10;

   logic                    clk;
   logic                    reset;
   logic [NUM_REQ-1:0]      req;
   logic [NUM_REQ*SIZE-1:0] req_len;
   logic [NUM_REQ-1:0]      grant;
   logic [NUM_REQ-1:0]      done;
   logic                    busy;
   logic [SIZE-1:0]         count;

   int tests_run    = 0;
   int tests_failed = 0;

   timer_arbiter #(.NUM_REQ(NUM_REQ), .SIZE(SIZE)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .req_len (req_len),
      .grant   (grant),
      .done    (done),
      .busy    (busy),
      .count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one full cycle; inputs set before this are seen at the rising edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_len(input int idx, input logic [SIZE-1:0] v);
      req_len[idx*SIZE +: SIZE] = v;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      req     = '0;
      req_len = '0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   // grant and done must never overlap, and each is one-hot or zero.
   always @(negedge clk) begin
      if (reset) begin
         if ((|grant && |done) || !$onehot0(grant) || !$onehot0(done))
            check("grant_done_excl", {grant, done}, 32'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [NUM_REQ-1:0] rr_exp [5];

   initial begin
      rr_exp[0] = 4'b0001;
      rr_exp[1] = 4'b0010;
      rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000;
      rr_exp[4] = 4'b0001;

      // Reset state
      reset   = 1'b0;
      req     = '0;
      req_len = '0;
      tick();
      check("rst_grant", grant, 0);
      check("rst_done",  done,  0);
      check("rst_busy",  busy,  0);
      check("rst_count", count, 0);
      reset = 1'b1;

      // Single request, length 3; len change mid-RUN must be ignored
      req = 4'b0001;
      set_len(0, 3);
      tick();
      check("single_grant0", grant, 4'b0001);
      check("single_count0", count, 0);
      check("single_busy0",  busy,  1);
      set_len(0, 7);
      tick();
      check("single_count1", count, 1);
      tick();
      check("single_count2", count, 2);
      check("single_grant2", grant, 4'b0001);
      tick();
      check("single_done",   done,  4'b0001);
      check("single_dgrant", grant, 0);
      check("single_dbusy",  busy,  1);
      check("single_dcount", count, 0);
      req = '0;
      tick();
      check("single_idle_busy", busy, 0);
      check("single_idle_done", done, 0);

      // Round-robin with all requesters held, length 1 each
      do_reset();
      req = 4'b1111;
      for (int i = 0; i < NUM_REQ; i++) set_len(i, 1);
      for (int g = 0; g < 5; g++) begin
         tick();
         check("rr_grant", grant, rr_exp[g]);
         check("rr_count", count, 0);
         tick();
         check("rr_done",  done,  rr_exp[g]);
         check("rr_dgrant", grant, 0);
         tick();
         check("rr_idle_grant", grant, 0);
         check("rr_idle_busy",  busy,  0);
      end
      req = '0;

      // Zero length behaves as length 1
      do_reset();
      req = 4'b0100;
      set_len(2, 0);
      tick();
      check("zero_grant", grant, 4'b0100);
      check("zero_count", count, 0);
      tick();
      check("zero_done",  done,  4'b0100);
      check("zero_dgrant", grant, 0);
      req = '0;
      tick();
      check("zero_idle_done", done, 0);

      // Abort after two grant cycles; next search starts at index 2
      do_reset();
      req = 4'b0010;
      set_len(1, 5);
      set_len(2, 2);
      tick();
      check("abort_grant0", grant, 4'b0010);
      tick();
      check("abort_count1", count, 1);
      req = 4'b0000;
      tick();
      check("abort_grant", grant, 0);
      check("abort_done",  done,  0);
      check("abort_count", count, 0);
      check("abort_busy",  busy,  0);
      req = 4'b0111;
      tick();
      check("abort_next_rr", grant, 4'b0100);
      req = '0;

      // Abort coinciding with final count yields no done pulse
      do_reset();
      req = 4'b0001;
      set_len(0, 2);
      tick();
      tick();
      check("coinc_count1", count, 1);
      req = '0;
      tick();
      check("coinc_done",  done,  0);
      check("coinc_grant", grant, 0);
      check("coinc_busy",  busy,  0);

      // Asynchronous reset mid-RUN, then index 0 wins first
      do_reset();
      req = 4'b0001;
      set_len(0, 10);
      tick();
      for (int i = 0; i < 4; i++) tick();
      check("rrun_count4", count, 4);
      reset = 1'b0;
      #1;
      check("rrun_grant", grant, 0);
      check("rrun_count", count, 0);
      check("rrun_busy",  busy,  0);
      check("rrun_done",  done,  0);
      tick();
      reset = 1'b1;
      req   = 4'b1001;
      set_len(0, 2);
      set_len(3, 2);
      tick();
      check("rrun_first", grant, 4'b0001);
      req = '0;

      // Maximum length: count reaches 1022 without wrap, then done
      do_reset();
      req = 4'b0001;
      set_len(0, 10'd1023);
      tick();
      check("max_count0", count, 0);
      for (int i = 0; i < 1022; i++) tick();
      check("max_count_last", count, 1022);
      check("max_grant_last", grant, 4'b0001);
      tick();
      check("max_done",  done,  4'b0001);
      check("max_count", count, 0);
      req = '0;
      tick();
      check("max_idle_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
